fm_phaseinc_gen: RTL and testbench

Upstream stage of the DDS in the FM modulator: accepts signed audio samples over a valid/ready handshake and converts each into a DDS phase increment, phaseinc = carrierinc + ((sample × kdev) >>> KDEV_SHIFT). A shift-add sequential multiplier forms the deviation term. The result is handed to the DDS only on an enableclk cycle, so the increment seen by the DDS phase accumulator changes in step with its own update rate.

---
 rtl/fm_pkg.sv | 15 +
 rtl/fm_phaseinc_gen_if.sv | 14 +
 rtl/fm_phaseinc_gen_seq_mult.sv | 53 +++++
 rtl/fm_phaseinc_gen.sv | 104 ++++++++++
 tb/tb_fm_phaseinc_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fm_pkg.sv
// Shared definitions for the FM modulator front end: FSM states and default widths.
package fm_pkg;

  localparam int NBITS_AUDIO = 16;
  localparam int NBITS_KDEV  = 16;
  localparam int NBITS_PHASE = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_ADD,
    ST_LOAD
  } fm_state_e;

endpackage

// File: rtl/fm_phaseinc_gen_if.sv
// Audio sample valid/ready channel into the phase-increment generator.
interface fm_phaseinc_gen_if #(
  parameter int NBITS_AUDIO = fm_pkg::NBITS_AUDIO
);
  import fm_pkg::*;

  logic signed [NBITS_AUDIO-1:0] audio_in;
  logic                          audio_valid;
  logic                          audio_ready;

  modport master (output audio_in, output audio_valid, input  audio_ready);
  modport slave  (input  audio_in, input  audio_valid, output audio_ready);

endinterface

// File: rtl/fm_phaseinc_gen_seq_mult.sv
// Signed x unsigned shift-add multiplier; one multiplier bit per clock, LSB first.
module seq_mult
  import fm_pkg::*;
#(
  parameter int NA = fm_pkg::NBITS_AUDIO,
  parameter int NB = fm_pkg::NBITS_KDEV
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [NA-1:0]    a,
  input  logic        [NB-1:0]    b,
  output logic                    done,
  output logic signed [NA+NB-1:0] product
);

  localparam int PW = NA + NB;
  localparam int CW = $clog2(NB + 1);

  logic signed [PW-1:0] acc_q;
  logic signed [PW-1:0] mcand_q;
  logic        [NB-1:0] mplier_q;
  logic        [CW-1:0] cnt_q;
  logic                 busy_q;

  // Partial sums may wrap mid-run; the final product always fits in PW bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{NB{a[NA-1]}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(NB);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q <<< 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // done marks the edge that performs the final step
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = acc_q;

endmodule

// File: rtl/fm_phaseinc_gen.sv
// Audio sample -> DDS phase increment, handed over on enableclk cycles.
// Optional FMPI_SAT_EN clamps the deviation term to +/-MAXDEV before the carrier add.
module fm_phaseinc_gen #(
  parameter int NBITS_AUDIO = fm_pkg::NBITS_AUDIO,
  parameter int NBITS_KDEV  = fm_pkg::NBITS_KDEV,
  parameter int KDEV_SHIFT  = 8,
  parameter int NBITS_PHASE = fm_pkg::NBITS_PHASE,
  parameter logic [NBITS_PHASE-1:0] MAXDEV = 'h0010_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enableclk,
  input  logic [NBITS_PHASE-1:0] carrierinc,
  input  logic [NBITS_KDEV-1:0]  kdev,
  fm_phaseinc_gen_if.slave       aud,
  output logic [NBITS_PHASE-1:0] phaseinc,
  output logic                   phaseinc_upd
);
  import fm_pkg::*;

  localparam int PW = NBITS_AUDIO + NBITS_KDEV;
  localparam logic signed [NBITS_PHASE-1:0] MAXDEV_S = MAXDEV;

  function automatic logic signed [NBITS_PHASE-1:0] to_phase(input logic signed [PW-1:0] x);
    logic signed [NBITS_PHASE-1:0] r;
    for (int i = 0; i < NBITS_PHASE; i++) r[i] = (i < PW) ? x[i] : x[PW-1];
    return r;
  endfunction

  function automatic logic signed [NBITS_PHASE-1:0] sat_dev(input logic signed [NBITS_PHASE-1:0] d);
    if (d > MAXDEV_S)  return MAXDEV_S;
    if (d < -MAXDEV_S) return -MAXDEV_S;
    return d;
  endfunction

  fm_state_e state_q, state_d;
  logic [NBITS_PHASE-1:0] carrier_q, pending_q, pending_d, phaseinc_q;
  logic                   upd_q, load_en, accept, mult_done;
  logic signed [PW-1:0]   product, prod_sh;
  logic signed [NBITS_PHASE-1:0] dev;

  assign aud.audio_ready = (state_q == ST_IDLE) && !reset;
  assign accept          = aud.audio_valid && aud.audio_ready;

  seq_mult #(.NA(NBITS_AUDIO), .NB(NBITS_KDEV)) u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (accept),
    .a       (aud.audio_in),
    .b       (kdev),
    .done    (mult_done),
    .product (product)
  );

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MULT;
      ST_MULT: if (mult_done) state_d = ST_ADD;
      ST_ADD:  state_d = ST_LOAD;
      ST_LOAD: if (enableclk) begin
        state_d = ST_IDLE;
        load_en = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ADD stage: scale the product and add the captured carrier (sum wraps)
  assign prod_sh = product >>> KDEV_SHIFT;
`ifdef FMPI_SAT_EN
  assign dev = sat_dev(to_phase(prod_sh));
`else
  assign dev = to_phase(prod_sh);
`endif
  assign pending_d = carrier_q + $unsigned(dev);

  always_ff @(posedge clock) begin
    if (accept) carrier_q <= carrierinc;
  end

  // LOAD stage: pending is only handed to the DDS on an enableclk cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= '0;
      phaseinc_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      if (state_q == ST_ADD) pending_q <= pending_d;
      if (load_en) phaseinc_q <= pending_q;
      upd_q <= load_en;
    end
  end

  assign phaseinc     = phaseinc_q;
  assign phaseinc_upd = upd_q;

endmodule

// File: tb/tb_fm_phaseinc_gen.sv
// Directed, table-driven bench for fm_phaseinc_gen with a few multi-cycle corner sequences.
module tb_fm_phaseinc_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enableclk;
  logic [31:0] carrierinc;
  logic [15:0] kdev;
  logic [31:0] phaseinc;
  logic        phaseinc_upd;

  int checks = 0;
  int errors = 0;

  fm_phaseinc_gen_if #(.NBITS_AUDIO(16)) aud ();

  fm_phaseinc_gen dut (
    .clock        (clock),
    .reset        (reset),
    .enableclk    (enableclk),
    .carrierinc   (carrierinc),
    .kdev         (kdev),
    .aud          (aud),
    .phaseinc     (phaseinc),
    .phaseinc_upd (phaseinc_upd)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic signed [15:0] sample;
    logic        [15:0] kdev;
    logic        [31:0] carrier;
    logic        [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_one(input string name, input logic signed [15:0] s, input logic [15:0] k,
                         input logic [31:0] c, input logic [31:0] exp);
    int n, lat, ups;
    logic [31:0] val;
    aud.audio_in    = s;
    kdev            = k;
    carrierinc      = c;
    aud.audio_valid = 1'b1;
    n = 0;
    while (!aud.audio_ready && n < 50) begin
      step();
      n++;
    end
    chk({name, "_ready_wait"}, (n < 50), 1);
    step();
    // scramble inputs after the accepting edge; the result must not change
    aud.audio_valid = 1'b0;
    aud.audio_in    = 16'h7ABC;
    kdev            = 16'h1234;
    carrierinc      = 32'hDEAD_BEEF;
    lat = -1; ups = 0; val = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (phaseinc_upd) begin
        ups++;
        if (lat < 0) begin
          lat = i;
          val = phaseinc;
        end
      end
    end
    chk({name, "_latency"}, lat, 18);
    chk({name, "_upd_count"}, ups, 1);
    chk({name, "_value"}, val, exp);
    chk({name, "_hold"}, phaseinc, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic        bad;
    int          acc_cyc[3];
    logic [31:0] got[3];
    logic signed [15:0] bs[3];
    logic [31:0] bexp[3];
    int          idx, nu;
    logic        rdy;

    vecs[0] = '{16'sd1000,   16'd256,   32'h1000_0000, 32'h1000_03E8};
    vecs[1] = '{-16'sd1,     16'd256,   32'h1000_0000, 32'h0FFF_FFFF};
`ifdef FMPI_SAT_EN
    vecs[2] = '{-16'sd32768, 16'd65535, 32'h1000_0000, 32'h0FF0_0000};
    vecs[3] = '{16'sd32767,  16'd65535, 32'h0000_0000, 32'h0010_0000};
`else
    vecs[2] = '{-16'sd32768, 16'd65535, 32'h1000_0000, 32'h0F80_0080};
    vecs[3] = '{16'sd32767,  16'd65535, 32'h0000_0000, 32'h007F_FE80};
`endif
    vecs[4] = '{-16'sd1000,  16'd512,   32'h1000_0000, 32'h0FFF_F830};
    vecs[5] = '{16'sd512,    16'd256,   32'hFFFF_FFFF, 32'h0000_01FF};
    vecs[6] = '{16'sd3,      16'd1,     32'hFFFF_FFFF, 32'hFFFF_FFFF};

    reset = 1'b1; enableclk = 1'b1; carrierinc = '0; kdev = '0;
    aud.audio_in = '0; aud.audio_valid = 1'b1;
    repeat (3) step();
    chk("rst_phaseinc", phaseinc, 32'h0);
    chk("rst_upd", phaseinc_upd, 0);
    chk("rst_ready_low", aud.audio_ready, 0);
    aud.audio_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_ready_high", aud.audio_ready, 1);

    for (int i = 0; i < 7; i++)
      run_one($sformatf("vec%0d", i), vecs[i].sample, vecs[i].kdev, vecs[i].carrier, vecs[i].exp);

    // enableclk held low: block parks in LOAD without touching phaseinc
    enableclk = 1'b0;
    aud.audio_in = 16'sd1000; kdev = 16'd256; carrierinc = 32'h2000_0000;
    aud.audio_valid = 1'b1;
    step();
    aud.audio_valid = 1'b0;
    repeat (17) step();
    prev = phaseinc;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (aud.audio_ready || phaseinc_upd || phaseinc !== prev) bad = 1'b1;
    end
    chk("gate_hold", bad, 0);
    enableclk = 1'b1;
    step();
    chk("gate_upd", phaseinc_upd, 1);
    chk("gate_value", phaseinc, 32'h2000_03E8);
    chk("gate_ready", aud.audio_ready, 1);
    step();
    chk("gate_upd_single", phaseinc_upd, 0);

    // back-to-back: valid held high across three samples
    bs[0] = 16'sd100;  bexp[0] = 32'h1000_0064;
    bs[1] = -16'sd100; bexp[1] = 32'h0FFF_FF9C;
    bs[2] = 16'sd2000; bexp[2] = 32'h1000_07D0;
    kdev = 16'd256; carrierinc = 32'h1000_0000;
    aud.audio_in = bs[0]; aud.audio_valid = 1'b1;
    idx = 0; nu = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      rdy = aud.audio_ready && aud.audio_valid;
      step();
      if (rdy && idx < 3) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) aud.audio_in = bs[idx];
        else aud.audio_valid = 1'b0;
      end
      if (phaseinc_upd) begin
        if (nu < 3) got[nu] = phaseinc;
        nu++;
      end
    end
    chk("b2b_accepts", idx, 3);
    chk("b2b_upds", nu, 3);
    if (idx == 3) begin
      chk("b2b_spacing01", acc_cyc[1] - acc_cyc[0], 19);
      chk("b2b_spacing12", acc_cyc[2] - acc_cyc[1], 19);
    end
    if (nu >= 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("b2b_value%0d", i), got[i], bexp[i]);
    end

    // reset in the middle of MULT discards the sample
    aud.audio_in = 16'sd1000; kdev = 16'd256; carrierinc = 32'h3000_0000;
    aud.audio_valid = 1'b1;
    step();
    aud.audio_valid = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    aud.audio_valid = 1'b1;
    step();
    chk("midrst_phaseinc", phaseinc, 32'h0);
    chk("midrst_upd", phaseinc_upd, 0);
    chk("midrst_ready_low", aud.audio_ready, 0);
    reset = 1'b0;
    aud.audio_valid = 1'b0;
    step();
    chk("midrst_ready", aud.audio_ready, 1);
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (phaseinc_upd || phaseinc !== 32'h0) bad = 1'b1;
    end
    chk("midrst_discard", bad, 0);
    run_one("post_rst", 16'sd1000, 16'd256, 32'h1000_0000, 32'h1000_03E8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
